// File: rtl/kmeans_iter_ctrl_k2_d5.sv
// rtl/kmeans_iter_ctrl_k2_d5.sv - k-means iteration sequencer for the k=2, d=5 distance pipeline
// Optional convergence early-exit is enabled by defining KMEANS_CONV_EN.
module kmeans_iter_ctrl_k2_d5 #(
  parameter int input_data_width = 16,
  parameter int PIPE_LAT         = 6,
  parameter int CNT_W            = 16,
  parameter int ACC_W            = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [CNT_W-1:0]              num_points,
  input  logic [7:0]                    max_iter,
  input  logic                          cent_wr_en,
  input  logic [3:0]                    cent_wr_sel,
  input  logic [input_data_width-1:0]   cent_wr_data,
  output logic                          mem_rd_en,
  output logic [CNT_W-1:0]              mem_rd_addr,
  input  logic [5*input_data_width-1:0] mem_rd_data,
  output logic [10*input_data_width-1:0] centroid_flat,
  output logic [5*input_data_width-1:0] pipe_in_data,
  input  logic [5*input_data_width-1:0] pipe_out_data,
  input  logic                          pipe_sel,
  output logic                          busy,
  output logic                          done,
`ifdef KMEANS_CONV_EN
  output logic                          converged,
`endif
  output logic [7:0]                    iter_count
);

  localparam int W      = input_data_width;
  localparam int NC     = 10;
  localparam int STEP_W = $clog2(ACC_W + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ACC_W);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_STREAM, S_DRAIN, S_DIVIDE, S_ITER_END, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      cent_q [NC];
  logic [ACC_W-1:0]  acc_q  [NC];
  logic [CNT_W-1:0]  cnt_q  [2];
  logic [CNT_W-1:0]  num_points_q;
  logic [CNT_W-1:0]  addr_q;
  logic [7:0]        max_iter_q;
  logic [7:0]        iter_q;
  logic [PIPE_LAT:0] vld_q;
  logic [3:0]        pair_q;
  logic [STEP_W-1:0] step_q;
  logic [CNT_W-1:0]  rem_q;
  logic [ACC_W-1:0]  quo_q;

  logic              start_ok;
  logic              acc_clr;
  logic              iter_last;
  logic              conv_stop;
  logic              cur_k;
  logic [CNT_W-1:0]  divisor;
  logic [CNT_W:0]    shifted;
  logic [CNT_W:0]    diff;
  logic              fits;
  logic [CNT_W-1:0]  rem_next;
  logic [ACC_W-1:0]  quo_next;
  logic              div_wr;
  logic [W-1:0]      div_mean;

  assign start_ok  = (state_q == S_IDLE) && start;
  assign acc_clr   = start_ok || (state_q == S_ITER_END);
  assign iter_last = ((iter_q + 8'd1) == max_iter_q);

  // Restoring divider datapath: remainder never exceeds the divisor, so the
  // sign of the trial subtraction decides the quotient bit.
  assign cur_k    = (pair_q >= 4'd5);
  assign divisor  = cnt_q[cur_k];
  assign shifted  = {rem_q, quo_q[ACC_W-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign fits     = ~diff[CNT_W];
  assign rem_next = fits ? diff[CNT_W-1:0] : shifted[CNT_W-1:0];
  assign quo_next = {quo_q[ACC_W-2:0], fits};
  assign div_wr   = (state_q == S_DIVIDE) && (step_q == LAST_STEP) && (divisor != '0);
  assign div_mean = quo_next[W-1:0];

  assign mem_rd_en    = (state_q == S_STREAM);
  assign mem_rd_addr  = addr_q;
  assign pipe_in_data = mem_rd_data;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign iter_count   = iter_q;

  // Flatten the centroid table for the pipeline, k0d0 in the LSBs
  always_comb begin
    centroid_flat = '0;
    for (int i = 0; i < NC; i++) centroid_flat[i*W +: W] = cent_q[i];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (num_points == '0 || max_iter == 8'd0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        if (addr_q == num_points_q - CNT_ONE) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // only the tail may still hold a valid: it is consumed this cycle
        if (vld_q[PIPE_LAT-1:0] == '0) state_d = S_DIVIDE;
      end
      S_DIVIDE: begin
        if (pair_q == 4'd9 && step_q == LAST_STEP) state_d = S_ITER_END;
      end
      S_ITER_END: begin
        state_d = (iter_last || conv_stop) ? S_DONE : S_STREAM;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latched run parameters, iteration counter and stream address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_points_q <= '0;
      max_iter_q   <= '0;
      iter_q       <= '0;
      addr_q       <= '0;
    end else begin
      if (start_ok) begin
        num_points_q <= num_points;
        max_iter_q   <= max_iter;
        iter_q       <= '0;
      end else if (state_q == S_ITER_END) begin
        iter_q <= iter_q + 8'd1;
      end
      if (state_q == S_STREAM && state_d == S_STREAM) addr_q <= addr_q + CNT_ONE;
      else                                            addr_q <= '0;
    end
  end

  // Valid tracker: a read becomes a pipeline output 1+PIPE_LAT cycles later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= {vld_q[PIPE_LAT-1:0], mem_rd_en};
  end

  // Per-centroid sums and counts from valid pipeline outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) acc_q[i] <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else if (acc_clr) begin
      for (int i = 0; i < NC; i++) acc_q[i] <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else if (vld_q[PIPE_LAT]) begin
      for (int i = 0; i < NC; i++) begin
        if (pipe_sel == (i >= 5))
          acc_q[i] <= acc_q[i] + ACC_W'(pipe_out_data[(i % 5)*W +: W]);
      end
      cnt_q[pipe_sel] <= cnt_q[pipe_sel] + CNT_ONE;
    end
  end

  // Divider sequencing: per pair one load step then ACC_W shift/subtract steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q <= '0;
      step_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else if (state_q == S_DIVIDE) begin
      if (step_q == '0) begin
        rem_q <= '0;
        quo_q <= acc_q[pair_q];
      end else begin
        rem_q <= rem_next;
        quo_q <= quo_next;
      end
      if (step_q == LAST_STEP) begin
        step_q <= '0;
        pair_q <= (pair_q == 4'd9) ? 4'd0 : pair_q + 4'd1;
      end else begin
        step_q <= step_q + STEP_ONE;
      end
    end else begin
      pair_q <= '0;
      step_q <= '0;
    end
  end

  // Centroid table: host writes in IDLE, mean write-back at the end of each pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) cent_q[i] <= '0;
    end else if (state_q == S_IDLE && cent_wr_en && cent_wr_sel < 4'd10) begin
      cent_q[cent_wr_sel] <= cent_wr_data;
    end else if (div_wr) begin
      cent_q[pair_q] <= div_mean;
    end
  end

`ifdef KMEANS_CONV_EN
  logic changed_q;
  logic converged_q;

  assign conv_stop = ~changed_q;
  assign converged = converged_q;

  // Sticky per-iteration change flag and run-level convergence status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed_q   <= 1'b0;
      converged_q <= 1'b0;
    end else begin
      if (state_d == S_STREAM && state_q != S_STREAM) changed_q <= 1'b0;
      else if (div_wr && div_mean != cent_q[pair_q]) changed_q <= 1'b1;
      if (start_ok) converged_q <= 1'b0;
      else if (state_q == S_ITER_END && state_d == S_DONE) converged_q <= ~changed_q;
    end
  end
`else
  assign conv_stop = 1'b0;
`endif

endmodule

// File: tb/tb_kmeans_iter_ctrl_k2_d5.sv
// tb/tb_kmeans_iter_ctrl_k2_d5.sv - self-checking bench for kmeans_iter_ctrl_k2_d5
module tb_kmeans_iter_ctrl_k2_d5;

  localparam int W  = 16;
  localparam int PL = 6;
  localparam int CW = 16;
  localparam int AW = 32;
  localparam int ITER_CYC = 1 + PL + 10*(AW+1) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [CW-1:0]   num_points = '0;
  logic [7:0]      max_iter = '0;
  logic            cent_wr_en = 1'b0;
  logic [3:0]      cent_wr_sel = '0;
  logic [W-1:0]    cent_wr_data = '0;
  logic            mem_rd_en;
  logic [CW-1:0]   mem_rd_addr;
  logic [5*W-1:0]  mem_rd_data = '0;
  logic [10*W-1:0] centroid_flat;
  logic [5*W-1:0]  pipe_in_data;
  logic [5*W-1:0]  pipe_out_data;
  logic            pipe_sel;
  logic            busy, done;
  logic [7:0]      iter_count;
`ifdef KMEANS_CONV_EN
  logic            converged;
`endif

  kmeans_iter_ctrl_k2_d5 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_points(num_points), .max_iter(max_iter),
    .cent_wr_en(cent_wr_en), .cent_wr_sel(cent_wr_sel), .cent_wr_data(cent_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .centroid_flat(centroid_flat), .pipe_in_data(pipe_in_data), .pipe_out_data(pipe_out_data),
    .pipe_sel(pipe_sel), .busy(busy), .done(done),
`ifdef KMEANS_CONV_EN
    .converged(converged),
`endif
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [W-1:0] pts [0:31][0:4];
  logic [W-1:0] m_cent [10];
  logic [W-1:0] hist [0:15][10];
  int  exp_t0 = 0, exp_n = 0, exp_iters = 0, exp_done_off = 0;
  bit  exp_conv = 0;
  bit  run_active = 0;
  bit  mon_en = 0;
  int  done_cnt = 0;
  int  last_done_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [5*W-1:0] pack_pt(input int p);
    logic [5*W-1:0] r;
    for (int d = 0; d < 5; d++) r[d*W +: W] = pts[p][d];
    return r;
  endfunction

  // nearest centroid by squared Euclidean distance, ties to centroid 0
  function automatic logic nearest(input logic [5*W-1:0] p, input logic [10*W-1:0] c);
    longint d0, d1, a, b0, b1;
    d0 = 0; d1 = 0;
    for (int d = 0; d < 5; d++) begin
      a  = longint'(p[d*W +: W]);
      b0 = longint'(c[d*W +: W]);
      b1 = longint'(c[(5+d)*W +: W]);
      d0 += (a - b0) * (a - b0);
      d1 += (a - b1) * (a - b1);
    end
    return (d1 < d0);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // point memory with one-cycle read latency
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= pack_pt(int'(mem_rd_addr));

  // distance/compare pipeline stand-in: PL register stages
  logic [5*W-1:0] pd [PL];
  logic           ps [PL];
  always @(posedge clk) begin
    pd[0] <= pipe_in_data;
    ps[0] <= nearest(pipe_in_data, centroid_flat);
    for (int i = 1; i < PL; i++) begin
      pd[i] <= pd[i-1];
      ps[i] <= ps[i-1];
    end
  end
  assign pipe_out_data = pd[PL-1];
  assign pipe_sel      = ps[PL-1];

  // whole-run reference: Lloyd iterations on the stored points
  task automatic model_run(input int n, input int maxit);
    logic [W-1:0]    c [10];
    longint          sum [10];
    int              cnt [2];
    bit              chg;
    logic [10*W-1:0] cf;
    logic            k;
    logic [W-1:0]    nv;
    for (int j = 0; j < 10; j++) c[j] = m_cent[j];
    exp_iters = 0;
    exp_conv  = 0;
    if (n > 0 && maxit > 0) begin
      for (int it = 0; it < maxit; it++) begin
        for (int j = 0; j < 10; j++) begin
          hist[it][j] = c[j];
          sum[j] = 0;
          cf[j*W +: W] = c[j];
        end
        cnt[0] = 0; cnt[1] = 0;
        for (int p = 0; p < n; p++) begin
          k = nearest(pack_pt(p), cf);
          for (int d = 0; d < 5; d++) sum[int'(k)*5+d] += longint'(pts[p][d]);
          cnt[int'(k)]++;
        end
        chg = 0;
        for (int j = 0; j < 10; j++) begin
          if (cnt[j/5] != 0) begin
            nv = W'(sum[j] / cnt[j/5]);
            if (nv != c[j]) chg = 1;
            c[j] = nv;
          end
        end
        exp_iters++;
`ifdef KMEANS_CONV_EN
        if (!chg) begin
          exp_conv = 1;
          break;
        end
`endif
      end
    end
    for (int j = 0; j < 10; j++) m_cent[j] = c[j];
    exp_done_off = 1 + exp_iters * (n + ITER_CYC);
  endtask

  // per-cycle compare of control outputs against the run timeline
  always @(negedge clk) begin : mon
    int o, rel, it;
    bit e_busy, e_done, e_en;
    if (mon_en) begin
      o      = cyc - exp_t0;
      e_busy = run_active && o >= 1 && o <= exp_done_off;
      e_done = run_active && o == exp_done_off;
      e_en   = 0; rel = 0; it = 0;
      if (e_busy && exp_iters > 0 && o < exp_done_off) begin
        rel  = (o - 1) % (exp_n + ITER_CYC);
        it   = (o - 1) / (exp_n + ITER_CYC);
        e_en = (rel < exp_n);
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("mem_rd_en", mem_rd_en, e_en);
      if (e_en) begin
        chk("mem_rd_addr", mem_rd_addr, rel);
        for (int j = 0; j < 10; j++) chk("stream_centroid", centroid_flat[j*W +: W], hist[it][j]);
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cent(input int sel, input int data);
    cent_wr_en   = 1'b1;
    cent_wr_sel  = sel[3:0];
    cent_wr_data = data[W-1:0];
    if (sel < 10) m_cent[sel] = data[W-1:0];
    wait_cycle();
    cent_wr_en = 1'b0;
  endtask

  task automatic set_cents(input int v0, input int v1);
    for (int d = 0; d < 5; d++) write_cent(d, v0);
    for (int d = 0; d < 5; d++) write_cent(5 + d, v1);
  endtask

  task automatic set_pts_scalar(input int p, input int v);
    for (int d = 0; d < 5; d++) pts[p][d] = v[W-1:0];
  endtask

  task automatic run(input int n, input int maxit, input bit poke);
    num_points = n[CW-1:0];
    max_iter   = maxit[7:0];
    start      = 1'b1;
    model_run(n, maxit);
    exp_t0     = cyc;
    exp_n      = n;
    done_cnt   = 0;
    run_active = 1;
    wait_cycle();
    start      = 1'b0;
    num_points = CW'($urandom);
    max_iter   = 8'($urandom);
    while (cyc - exp_t0 <= exp_done_off) begin
      if (poke && cyc - exp_t0 == 4) begin
        cent_wr_en   = 1'b1;
        cent_wr_sel  = 4'd9;
        cent_wr_data = 16'd555;
      end else begin
        cent_wr_en = 1'b0;
      end
      wait_cycle();
    end
    cent_wr_en = 1'b0;
    chk("done_pulses", done_cnt, 1);
    chk("iter_count", iter_count, exp_iters);
    for (int j = 0; j < 10; j++) chk("final_centroid", centroid_flat[j*W +: W], m_cent[j]);
`ifdef KMEANS_CONV_EN
    chk("converged", converged, exp_conv);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int j = 0; j < 10; j++) m_cent[j] = '0;
    wait_cycle();
    wait_cycle();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_rd_addr", mem_rd_addr, 0);
    chk("rst_centroid_any", longint'(|centroid_flat), 0);
    chk("rst_iter_count", iter_count, 0);
    rst_n = 1'b1;
    wait_cycle();
    mon_en = 1;

    // scenario: two clear clusters
    set_cents(0, 100);
    set_pts_scalar(0, 10); set_pts_scalar(1, 20); set_pts_scalar(2, 90); set_pts_scalar(3, 110);
    run(4, 1, 0);
    for (int d = 0; d < 5; d++) chk("s1_c0_literal", centroid_flat[d*W +: W], 15);
    for (int d = 0; d < 5; d++) chk("s1_c1_literal", centroid_flat[(5+d)*W +: W], 100);
    chk("s1_iter_literal", iter_count, 1);
    chk("s1_done_latency", last_done_cyc - exp_t0, 343);

    // scenario: empty cluster kept, host write while busy ignored
    set_cents(0, 1000);
    set_pts_scalar(0, 1); set_pts_scalar(1, 2); set_pts_scalar(2, 3);
    run(3, 1, 1);
    for (int d = 0; d < 5; d++) chk("s2_c0_literal", centroid_flat[d*W +: W], 2);
    for (int d = 0; d < 5; d++) chk("s2_c1_literal", centroid_flat[(5+d)*W +: W], 1000);

    // out-of-range write select in IDLE
    write_cent(12, 777);
    wait_cycle();
    for (int j = 0; j < 10; j++) chk("sel12_ignored", centroid_flat[j*W +: W], m_cent[j]);

    // degenerate runs
    run(4, 0, 0);
    chk("zero_iter_latency", last_done_cyc - exp_t0, 1);
    run(0, 2, 0);
    chk("zero_pts_latency", last_done_cyc - exp_t0, 1);

    // asynchronous reset during STREAM
    mon_en     = 0;
    num_points = 16'd10;
    max_iter   = 8'd1;
    start      = 1'b1;
    wait_cycle();
    start = 1'b0;
    wait_cycle(); wait_cycle();
    chk("pre_rst_streaming", mem_rd_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_mem_rd_en", mem_rd_en, 0);
    chk("async_rst_centroid_any", longint'(|centroid_flat), 0);
    wait_cycle();
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) m_cent[j] = '0;
    wait_cycle();
    mon_en = 1;
    set_cents(0, 100);
    set_pts_scalar(0, 10); set_pts_scalar(1, 20); set_pts_scalar(2, 90); set_pts_scalar(3, 110);
    run(4, 1, 0);
    chk("post_rst_c0_literal", centroid_flat[0 +: W], 15);

`ifdef KMEANS_CONV_EN
    set_cents(0, 100);
    run(4, 10, 0);
    chk("conv_iter_literal", iter_count, 2);
    chk("conv_flag_literal", converged, 1);
`endif

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      int n, mi;
      n  = $urandom_range(1, 20);
      mi = $urandom_range(1, 3);
      for (int j = 0; j < 10; j++) write_cent(j, $urandom_range(0, 65535));
      for (int p = 0; p < n; p++)
        for (int d = 0; d < 5; d++) pts[p][d] = W'($urandom_range(0, 65535));
      run(n, mi, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
